sr_latch_ctrl: RTL

Synchronous controller that shares one SR latch among N requesters. It arbitrates set/reset requests round-robin and drives the latch `s`/`r` inputs with registered pulses of fixed width. It guarantees `s` and `r` are never high together and inserts a non-overlap gap between operations. It sits between the clocked request logic and the asynchronous `SRLatch` cell, and replaces direct `s`/`r` driving by multiple agents.

---
 rtl/sr_latch_ctrl.sv | 131 +++++++++++++
 1 files changed

// File: rtl/sr_latch_ctrl.sv
// Round-robin controller sharing one SR latch among N requesters; drives registered s/r pulses with a gap.
// Optional q readback check enabled by defining SRLATCH_CTRL_VERIFY_EN (err tied low otherwise).
module sr_latch_ctrl #(
  parameter int N       = 4,
  parameter int PULSE_W = 2,
  parameter int GAP_W   = 1
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [N-1:0] req,
  input  logic [N-1:0] op,
  output logic [N-1:0] ack,
  output logic         s,
  output logic         r,
  input  logic         q,
  output logic         busy,
  output logic         err
);

  localparam int PW = (N > 1) ? $clog2(N) : 1;
  localparam logic [3:0] PULSE_LAST = 4'(PULSE_W - 1);
  localparam logic [3:0] GAP_LAST   = 4'(GAP_W - 1);

  typedef enum logic [1:0] {IDLE, PULSE, GAP} state_t;

  state_t         r_state;
  logic [PW-1:0]  r_ptr;
  logic [PW-1:0]  r_g;
  logic           r_opg;
  logic [3:0]     r_cnt;

  logic           w_hit;
  logic [PW-1:0]  w_gnt;
  logic [PW-1:0]  w_ptr_next;
  logic [N-1:0]   w_ack_vec;
  int unsigned    w_idx;

  // First asserted requester at or after the pointer, wrapping modulo N.
  always_comb begin
    w_hit = 1'b0;
    w_gnt = '0;
    w_idx = 0;
    for (int unsigned i = 0; i < N; i++) begin
      w_idx = int'(r_ptr) + i;
      if (w_idx >= N) w_idx = w_idx - N;
      if (!w_hit && req[w_idx]) begin
        w_hit = 1'b1;
        w_gnt = PW'(w_idx);
      end
    end
  end

  assign w_ptr_next = (w_gnt == PW'(N - 1)) ? '0 : PW'(w_gnt + 1'b1);
  assign w_ack_vec  = N'(1) << r_g;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
      r_ptr   <= '0;
      r_g     <= '0;
      r_opg   <= 1'b0;
      r_cnt   <= '0;
      s       <= 1'b0;
      r       <= 1'b0;
      ack     <= '0;
      busy    <= 1'b0;
    end else begin
      ack <= '0;
      case (r_state)
        IDLE: begin
          if (w_hit) begin
            r_g     <= w_gnt;
            r_opg   <= op[w_gnt];
            r_ptr   <= w_ptr_next;
            s       <= op[w_gnt];
            r       <= ~op[w_gnt];
            busy    <= 1'b1;
            r_cnt   <= '0;
            r_state <= PULSE;
          end
        end
        PULSE: begin
          if (r_cnt == PULSE_LAST) begin
            s       <= 1'b0;
            r       <= 1'b0;
            r_cnt   <= '0;
            r_state <= GAP;
            // ack is registered, so it is launched on entry to the last gap cycle.
            if (GAP_LAST == 4'd0) ack <= w_ack_vec;
          end else begin
            s     <= r_opg;
            r     <= ~r_opg;
            r_cnt <= r_cnt + 4'd1;
          end
        end
        GAP: begin
          if (r_cnt == GAP_LAST) begin
            r_state <= IDLE;
            busy    <= 1'b0;
            r_cnt   <= '0;
          end else begin
            r_cnt <= r_cnt + 4'd1;
            if (r_cnt + 4'd1 == GAP_LAST) ack <= w_ack_vec;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

`ifdef SRLATCH_CTRL_VERIFY_EN
  logic r_err;

  // q is checked during the ack cycle; the flag shows from the following cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= 1'b0;
    end else if (r_state == GAP && r_cnt == GAP_LAST && q != r_opg) begin
      r_err <= 1'b1;
    end
  end

  assign err = r_err;
`else
  logic w_unused_q;

  assign w_unused_q = q;
  assign err        = 1'b0;
`endif

endmodule
